// File: rtl/gpu_wb_pkg.sv
// Shared types and constants for the shader-core result writeback path.
package gpu_wb_pkg;

  localparam int DATA_W  = 32;
  localparam int TAG_W   = 8;
  localparam int NUM_SRC = 3;

  // Execution unit that produced a result.
  typedef enum logic [1:0] {
    SRC_ALU    = 2'd0,
    SRC_TMU    = 2'd1,
    SRC_TENSOR = 2'd2
  } src_id_t;

  // One result as it travels through a source FIFO.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } wb_entry_t;

  // Successor in the round-robin order ALU -> TMU -> TENSOR -> ALU.
  function automatic src_id_t next_src(input src_id_t s);
    case (s)
      SRC_ALU:    next_src = SRC_TMU;
      SRC_TMU:    next_src = SRC_TENSOR;
      default:    next_src = SRC_ALU;
    endcase
  endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// Small synchronous FIFO buffering results of one execution unit.
// Pushes into a full FIFO and pops from an empty one are ignored.
module wb_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 40
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array; payload needs no reset because count guards its use.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/result_writeback_arbiter.sv
// Funnels ALU, TMU and tensor results onto the single register-file
// writeback port through per-source FIFOs, a round-robin arbiter and a
// registered valid/ready output stage.
module result_writeback_arbiter #(
  parameter int DATA_W     = gpu_wb_pkg::DATA_W,
  parameter int TAG_W      = gpu_wb_pkg::TAG_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_res_valid,
  output logic              alu_res_ready,
  input  logic [DATA_W-1:0] alu_res_data,
  input  logic [TAG_W-1:0]  alu_res_tag,
  input  logic              tmu_res_valid,
  output logic              tmu_res_ready,
  input  logic [DATA_W-1:0] tmu_res_data,
  input  logic [TAG_W-1:0]  tmu_res_tag,
  input  logic              tensor_res_valid,
  output logic              tensor_res_ready,
  input  logic [DATA_W-1:0] tensor_res_data,
  input  logic [TAG_W-1:0]  tensor_res_tag,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [TAG_W-1:0]  wb_tag,
  output logic [1:0]        wb_src,
  output logic              idle
);

  import gpu_wb_pkg::*;

  localparam int EW = DATA_W + TAG_W;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_SRC-1:0] in_valid;
  logic [EW-1:0]      in_entry [NUM_SRC];
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;
  logic [NUM_SRC-1:0] full;
  logic [NUM_SRC-1:0] empty;
  logic [EW-1:0]      head [NUM_SRC];
  logic [CW-1:0]      count [NUM_SRC];

  logic [3:0]         nonempty;
  logic               any_pending;
  logic               load;
  src_id_t            last_grant;
  src_id_t            cand0;
  src_id_t            cand1;
  src_id_t            cand2;
  src_id_t            grant;
  logic [EW-1:0]      grant_entry;

  assign in_valid    = {tensor_res_valid, tmu_res_valid, alu_res_valid};
  assign in_entry[0] = {alu_res_data, alu_res_tag};
  assign in_entry[1] = {tmu_res_data, tmu_res_tag};
  assign in_entry[2] = {tensor_res_data, tensor_res_tag};

  // Ready depends only on FIFO occupancy, never on wb_ready.
  assign alu_res_ready    = !full[0];
  assign tmu_res_ready    = !full[1];
  assign tensor_res_ready = !full[2];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign push[i] = in_valid[i] && !full[i];
    assign pop[i]  = load && (grant == src_id_t'(i));

    wb_result_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (EW)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[i]),
      .pop   (pop[i]),
      .din   (in_entry[i]),
      .dout  (head[i]),
      .full  (full[i]),
      .empty (empty[i]),
      .count (count[i])
    );
  end

  assign nonempty    = {1'b0, ~empty};
  assign any_pending = |nonempty;
  assign load        = (!wb_valid || wb_ready) && any_pending;
  assign idle        = (count[0] == '0) && (count[1] == '0) && (count[2] == '0) && !wb_valid;

  // Search order begins at the source after the last one granted.
  assign cand0 = next_src(last_grant);
  assign cand1 = next_src(cand0);
  assign cand2 = next_src(cand1);

  // Pick the first non-empty FIFO in round-robin order.
  always_comb begin
    grant = cand2;
    if (nonempty[cand0]) begin
      grant = cand0;
    end else if (nonempty[cand1]) begin
      grant = cand1;
    end else begin
      grant = cand2;
    end
  end

  // Select the head entry of the granted FIFO.
  always_comb begin
    grant_entry = head[0];
    case (grant)
      SRC_ALU:    grant_entry = head[0];
      SRC_TMU:    grant_entry = head[1];
      SRC_TENSOR: grant_entry = head[2];
      default:    grant_entry = head[0];
    endcase
  end

  // Output register and round-robin pointer; payload holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid   <= 1'b0;
      wb_data    <= '0;
      wb_tag     <= '0;
      wb_src     <= 2'd0;
      last_grant <= SRC_TENSOR;
    end else if (load) begin
      wb_valid   <= 1'b1;
      wb_data    <= grant_entry[EW-1:TAG_W];
      wb_tag     <= grant_entry[TAG_W-1:0];
      wb_src     <= grant;
      last_grant <= grant;
    end else if (wb_ready) begin
      wb_valid   <= 1'b0;
    end
  end

endmodule
